// File: rtl/mcp3008_spi_responder_if.sv
// SPI pin bundle between an MCP3008 master and the responder.
// The master drives sck/cs/mosi, the responder drives miso/oe.
interface mcp3008_spi_responder_if;
  logic spi_sck;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;
  logic miso_oe;

  modport master (
    output spi_sck,
    output spi_cs,
    output spi_mosi,
    input  spi_miso,
    input  miso_oe
  );

  modport slave (
    input  spi_sck,
    input  spi_cs,
    input  spi_mosi,
    output spi_miso,
    output miso_oe
  );
endinterface

// File: rtl/mcp3008_spi_responder.sv
// MCP3008 ADC emulator: oversampled SPI slave returning ch_data values.
// Define MCP3008_LSB_TAIL_EN to repeat B1..B9 LSB-first after B0.
module mcp3008_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HALF    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mcp3008_spi_responder_if.slave spi,
  input  logic [79:0] ch_data,
  output logic        conv_valid,
  output logic        conv_single,
  output logic [2:0]  conv_channel,
  output logic [9:0]  conv_value
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (MIN_HALF < 1) begin : g_bad_half
    $error("MIN_HALF must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    OUT,
    TAIL
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic        start_q, start_d;
  logic [1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [2:0]  cmd_sh_q, cmd_sh_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic [3:0]  tail_cnt_q, tail_cnt_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        valid_q, valid_d;
  logic        single_q, single_d;
  logic [2:0]  channel_q, channel_d;
  logic [9:0]  value_q, value_d;

  logic        sck_s;
  logic        cs_s;
  logic        mosi_s;
  logic        sck_rise;
  logic        sck_fall;
  logic [2:0]  sel;
  logic [2:0]  sel_n;
  logic [9:0]  in_p;
  logic [9:0]  in_n;
  logic [10:0] diff;
  logic [9:0]  sample;

  // Synchronizer shift chains and edge-detect history.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi.spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Sample-and-hold value for the channel addressed on the D0 rise.
  always_comb begin
    sel    = {cmd_sh_q[1:0], mosi_s};
    sel_n  = {sel[2:1], ~sel[0]};
    in_p   = ch_data[int'(sel)*10 +: 10];
    in_n   = ch_data[int'(sel_n)*10 +: 10];
    diff   = {1'b0, in_p} - {1'b0, in_n};
    if (cmd_sh_q[2]) begin
      sample = in_p;
    end else if (diff[10]) begin
      sample = 10'd0;
    end else begin
      sample = diff[9:0];
    end
  end

  // Frame state machine; chip-select release overrides any SCK edge.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    start_d    = start_q;
    cmd_cnt_d  = cmd_cnt_q;
    cmd_sh_d   = cmd_sh_q;
    out_cnt_d  = out_cnt_q;
    tail_cnt_d = tail_cnt_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    valid_d    = 1'b0;
    single_d   = single_q;
    channel_d  = channel_q;
    value_d    = value_q;
    if (cs_s) begin
      state_d    = IDLE;
      armed_d    = 1'b1;
      start_d    = 1'b0;
      cmd_cnt_d  = 2'd0;
      out_cnt_d  = 4'd0;
      tail_cnt_d = 4'd0;
      miso_d     = 1'b0;
      oe_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = CMD;
            armed_d = 1'b0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            if (!start_q) begin
              start_d = mosi_s;
            end else if (cmd_cnt_q != 2'd3) begin
              cmd_cnt_d = cmd_cnt_q + 2'd1;
              cmd_sh_d  = {cmd_sh_q[1:0], mosi_s};
            end else begin
              cmd_cnt_d = 2'd0;
              start_d   = 1'b0;
              valid_d   = 1'b1;
              single_d  = cmd_sh_q[2];
              channel_d = sel;
              value_d   = sample;
              out_cnt_d = 4'd0;
              state_d   = OUT;
            end
          end
        end
        OUT: begin
          if (sck_fall) begin
            oe_d = 1'b1;
            if (out_cnt_q == 4'd0) begin
              miso_d = 1'b0;
            end else begin
              miso_d = value_q[4'd10 - out_cnt_q];
            end
            if (out_cnt_q == 4'd10) begin
              out_cnt_d  = 4'd0;
              tail_cnt_d = 4'd0;
              state_d    = TAIL;
            end else begin
              out_cnt_d = out_cnt_q + 4'd1;
            end
          end
        end
        TAIL: begin
          if (sck_fall) begin
            miso_d = 1'b0;
            if (tail_cnt_q != 4'd9) begin
              tail_cnt_d = tail_cnt_q + 4'd1;
`ifdef MCP3008_LSB_TAIL_EN
              miso_d = value_q[tail_cnt_q + 4'd1];
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Register bank; sync chains reset low so a held-low CS never arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      start_q     <= 1'b0;
      cmd_cnt_q   <= 2'd0;
      cmd_sh_q    <= 3'd0;
      out_cnt_q   <= 4'd0;
      tail_cnt_q  <= 4'd0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      valid_q     <= 1'b0;
      single_q    <= 1'b0;
      channel_q   <= 3'd0;
      value_q     <= 10'd0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      armed_q     <= armed_d;
      start_q     <= start_d;
      cmd_cnt_q   <= cmd_cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      out_cnt_q   <= out_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      valid_q     <= valid_d;
      single_q    <= single_d;
      channel_q   <= channel_d;
      value_q     <= value_d;
    end
  end

  assign spi.spi_miso = miso_q;
  assign spi.miso_oe  = oe_q;
  assign conv_valid   = valid_q;
  assign conv_single  = single_q;
  assign conv_channel = channel_q;
  assign conv_value   = value_q;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Directed bench for the MCP3008 responder.
// Master samples MISO just before each SCK fall.
module tb_mcp3008_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [79:0] ch_data;
  logic        conv_valid;
  logic        conv_single;
  logic [2:0]  conv_channel;
  logic [9:0]  conv_value;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;

  logic rxm [0:31];
  logic rxo [0:31];

  mcp3008_spi_responder_if spi_if();

  mcp3008_spi_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi_if),
    .ch_data      (ch_data),
    .conv_valid   (conv_valid),
    .conv_single  (conv_single),
    .conv_channel (conv_channel),
    .conv_value   (conv_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (conv_valid === 1'b1) vcnt++;

  function automatic logic [9:0] word(input int s);
    logic [9:0] w;
    for (int k = 0; k < 10; k++) w[9-k] = rxm[s+k];
    return w;
  endfunction

  task automatic clocks(input int n, input logic [7:0] cmd,
                        input int len, input int chg_clk,
                        input logic [79:0] chg_data);
    for (int i = 0; i < n; i++) begin
      if (i == chg_clk) ch_data = chg_data;
      spi_if.spi_mosi = (i < len) ? cmd[len-1-i] : 1'b0;
      repeat (4) @(negedge clk);
      spi_if.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      rxm[i] = spi_if.spi_miso;
      rxo[i] = spi_if.miso_oe;
      spi_if.spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [7:0] cmd,
                       input int len, input int chg_clk,
                       input logic [79:0] chg_data);
    spi_if.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    clocks(n, cmd, len, chg_clk, chg_data);
    repeat (4) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({spi_if.spi_miso, spi_if.miso_oe, conv_valid, conv_single,
         conv_channel, conv_value} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {spi_if.spi_miso, spi_if.miso_oe, conv_valid,
                conv_single, conv_channel, conv_value});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single();
    int v0;
    ch_data = '0;
    ch_data[19:10] = 10'h2A5;
    v0 = vcnt;
    frame(24, 8'b11001, 5, -1, '0);
    total++;
    if (vcnt - v0 !== 1) begin
      bad++; $display("FAIL single_valid got=%0d exp=1", vcnt - v0);
    end
    total++;
    if (conv_channel !== 3'd1 || conv_single !== 1'b1) begin
      bad++; $display("FAIL single_cmd got=%0d/%0d exp=1/1",
                      conv_channel, conv_single);
    end
    total++;
    if (conv_value !== 10'h2A5) begin
      bad++; $display("FAIL single_value got=%h exp=2a5", conv_value);
    end
    total++;
    if (rxo[4] !== 1'b0 || rxo[5] !== 1'b1 || rxm[5] !== 1'b0) begin
      bad++; $display("FAIL single_null got=%b%b%b exp=010",
                      rxo[4], rxo[5], rxm[5]);
    end
    total++;
    if (word(6) !== 10'h2A5) begin
      bad++; $display("FAIL single_miso got=%h exp=2a5", word(6));
    end
    total++;
    if (spi_if.miso_oe !== 1'b0) begin
      bad++; $display("FAIL single_oe_release got=%b exp=0",
                      spi_if.miso_oe);
    end
  endtask

  task automatic test_leading_zeros();
    logic [79:0] later;
    ch_data = '0;
    ch_data[79:70] = 10'h3FF;
    later = '0;
    frame(24, 8'b00011111, 8, 10, later);
    total++;
    if (conv_channel !== 3'd7 || conv_single !== 1'b1) begin
      bad++; $display("FAIL lz_cmd got=%0d/%0d exp=7/1",
                      conv_channel, conv_single);
    end
    total++;
    if (word(9) !== 10'h3FF || conv_value !== 10'h3FF) begin
      bad++; $display("FAIL lz_hold got=%h/%h exp=3ff/3ff",
                      word(9), conv_value);
    end
  endtask

  task automatic test_diff();
    ch_data = '0;
    ch_data[29:20] = 10'd100;
    ch_data[39:30] = 10'd300;
    frame(16, 8'b10010, 5, -1, '0);
    total++;
    if (conv_value !== 10'd0 || conv_single !== 1'b0 ||
        conv_channel !== 3'd2 || word(6) !== 10'd0) begin
      bad++; $display("FAIL diff_sat got=%0d/%0d/%0d/%0d exp=0/0/2/0",
                      conv_value, conv_single, conv_channel, word(6));
    end
    frame(16, 8'b10011, 5, -1, '0);
    total++;
    if (conv_value !== 10'd200 || conv_channel !== 3'd3 ||
        word(6) !== 10'd200) begin
      bad++; $display("FAIL diff_pos got=%0d/%0d/%0d exp=200/3/200",
                      conv_value, conv_channel, word(6));
    end
  endtask

  task automatic test_abort();
    ch_data = '0;
    ch_data[19:10] = 10'h2A5;
    ch_data[9:0]   = 10'h155;
    spi_if.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    clocks(9, 8'b11001, 5, -1, '0);
    repeat (4) @(negedge clk);
    total++;
    if (spi_if.miso_oe !== 1'b1 || spi_if.spi_miso !== 1'b0 ||
        rxm[8] !== 1'b1) begin
      bad++; $display("FAIL abort_pre got=%b%b%b exp=101",
                      spi_if.miso_oe, spi_if.spi_miso, rxm[8]);
    end
    spi_if.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (spi_if.miso_oe !== 1'b0 || spi_if.spi_miso !== 1'b0) begin
      bad++; $display("FAIL abort_release got=%b%b exp=00",
                      spi_if.miso_oe, spi_if.spi_miso);
    end
    repeat (8) @(negedge clk);
    frame(16, 8'b11000, 5, -1, ch_data);
    total++;
    if (word(6) !== 10'h155 || conv_channel !== 3'd0) begin
      bad++; $display("FAIL abort_next got=%h/%0d exp=155/0",
                      word(6), conv_channel);
    end
  endtask

  task automatic test_tail();
    logic [9:0] v;
    logic       e;
    v = 10'h301;
    ch_data = '0;
    ch_data[49:40] = v;
    frame(28, 8'b11100, 5, -1, ch_data);
    total++;
    if (word(6) !== v) begin
      bad++; $display("FAIL tail_word got=%h exp=301", word(6));
    end
    for (int k = 0; k < 12; k++) begin
`ifdef MCP3008_LSB_TAIL_EN
      e = (k < 9) ? v[k+1] : 1'b0;
`else
      e = 1'b0;
`endif
      total++;
      if (rxm[16+k] !== e || rxo[16+k] !== 1'b1) begin
        bad++; $display("FAIL tail_bit%0d got=%b oe=%b exp=%b",
                        k, rxm[16+k], rxo[16+k], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    logic any_oe;
    ch_data = '0;
    ch_data[19:10] = 10'h2A5;
    spi_if.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    clocks(8, 8'b11001, 5, -1, '0);
    total++;
    if (rxo[7] !== 1'b1) begin
      bad++; $display("FAIL rmid_in_out got=%b exp=1", rxo[7]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({spi_if.spi_miso, spi_if.miso_oe, conv_valid, conv_single,
         conv_channel, conv_value} !== 17'd0) begin
      bad++; $display("FAIL rmid_async got=%h exp=0",
                      {spi_if.spi_miso, spi_if.miso_oe, conv_valid,
                       conv_single, conv_channel, conv_value});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    clocks(16, 8'b11001, 5, -1, '0);
    any_oe = 1'b0;
    for (int i = 0; i < 16; i++) any_oe |= rxo[i];
    total++;
    if (vcnt != v0 || any_oe !== 1'b0) begin
      bad++; $display("FAIL rmid_wait got=%0d/%b exp=0/0",
                      vcnt - v0, any_oe);
    end
    spi_if.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    frame(16, 8'b11001, 5, -1, ch_data);
    total++;
    if (word(6) !== 10'h2A5) begin
      bad++; $display("FAIL rmid_fresh got=%h exp=2a5", word(6));
    end
  endtask

  initial begin
    spi_if.spi_cs   = 1'b1;
    spi_if.spi_sck  = 1'b0;
    spi_if.spi_mosi = 1'b0;
    ch_data = '0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_leading_zeros();
    test_diff();
    test_abort();
    test_tail();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
